ibex_rf_backing_store: RTL and testbench

// - Memory-side responder for register-file context spill/load traffic on the Ibex data

---
 rtl/ibex_rf_backing_store.sv | 187 ++++++++++++++++++
 tb/tb_ibex_rf_backing_store.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_backing_store.sv
// rtl/ibex_rf_backing_store.sv - flop-based register-context store answering the Ibex data bus, with a per-context clear sequencer
// Optional per-context valid bits: define IBEX_RFSTORE_CTX_VALID_EN.
module ibex_rf_backing_store #(
    parameter logic [31:0] BaseAddr    = 32'h0001_0000,
    parameter int          NumCtx      = 4,
    parameter int          RespLatency = 1,
    localparam int         CtxW        = (NumCtx > 1) ? $clog2(NumCtx) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            data_req_i,
    output logic            data_gnt_o,
    input  logic            data_we_i,
    input  logic [3:0]      data_be_i,
    input  logic [31:0]     data_addr_i,
    input  logic [31:0]     data_wdata_i,
    output logic            data_rvalid_o,
    output logic [31:0]     data_rdata_o,
    output logic            data_err_o,
    input  logic            clear_req_i,
    input  logic [CtxW-1:0] clear_ctx_i,
    output logic            clear_busy_o,
    output logic            clear_done_o
);

    localparam int CW = $clog2(NumCtx);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [CtxW-1:0] clr_ctx_q, clr_ctx_d;

    logic [31:0] mem_q [NumCtx][32];
    logic [31:0] mem_d [NumCtx][32];

    logic [RespLatency-1:0] pv_q, pv_d;
    logic [RespLatency-1:0] pe_q, pe_d;
    logic [31:0]            pd_q [RespLatency];
    logic [31:0]            pd_d [RespLatency];

    logic            hit;
    logic [CtxW-1:0] acc_ctx;
    logic [4:0]      acc_word;
    logic            resp_err;
    logic [31:0]     resp_rdata;
    logic            unused_addr_bits;

    assign hit              = (data_addr_i >> (7 + CW)) == (BaseAddr >> (7 + CW));
    assign acc_ctx          = data_addr_i[7 +: CtxW] & CtxW'(NumCtx - 1);
    assign acc_word         = data_addr_i[6:2];
    assign unused_addr_bits = ^data_addr_i[1:0];

    // Reset gates the grant so every output is quiet while rst_i is high.
    assign data_gnt_o   = data_req_i & (state_q == ST_IDLE) & ~clear_req_i & ~rst_i;
    assign clear_busy_o = (state_q == ST_CLEAR);
    assign clear_done_o = (state_q == ST_DONE);

`ifdef IBEX_RFSTORE_CTX_VALID_EN
    logic [NumCtx-1:0] valid_q, valid_d;
`endif

    always_comb begin
        resp_err   = 1'b0;
        resp_rdata = '0;
        if (!hit) begin
            resp_err = 1'b1;
        end else if (!data_we_i) begin
`ifdef IBEX_RFSTORE_CTX_VALID_EN
            if (!valid_q[acc_ctx]) begin
                resp_err = 1'b1;
            end else begin
                resp_rdata = mem_q[acc_ctx][acc_word];
            end
`else
            resp_rdata = mem_q[acc_ctx][acc_word];
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_ctx_d = clr_ctx_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_ctx_d = clear_ctx_i;
                    cnt_d     = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grants never occur outside IDLE, so bus writes and clear writes cannot collide.
    always_comb begin
        mem_d = mem_q;
        if (data_gnt_o && hit && data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_d[acc_ctx][acc_word][8*b +: 8] = data_wdata_i[8*b +: 8];
                end
            end
        end
        if (state_q == ST_CLEAR) begin
            mem_d[clr_ctx_q][cnt_q] = '0;
        end
    end

`ifdef IBEX_RFSTORE_CTX_VALID_EN
    always_comb begin
        valid_d = valid_q;
        if (data_gnt_o && hit && data_we_i && (data_be_i != 4'b0000)) begin
            valid_d[acc_ctx] = 1'b1;
        end
        if ((state_q == ST_CLEAR) && (cnt_q == 5'd31)) begin
            valid_d[clr_ctx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end
`endif

    always_comb begin
        pv_d = pv_q;
        pe_d = pe_q;
        pd_d = pd_q;
        for (int i = RespLatency - 1; i > 0; i--) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
        pv_d[0] = data_gnt_o;
        pe_d[0] = data_gnt_o & resp_err;
        pd_d[0] = data_gnt_o ? resp_rdata : 32'h0;
    end

    assign data_rvalid_o = pv_q[RespLatency-1];
    assign data_err_o    = pe_q[RespLatency-1];
    assign data_rdata_o  = pd_q[RespLatency-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            clr_ctx_q <= '0;
            pv_q      <= '0;
            pe_q      <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                pd_q[i] <= '0;
            end
            for (int c = 0; c < NumCtx; c++) begin
                for (int w = 0; w < 32; w++) begin
                    mem_q[c][w] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_ctx_q <= clr_ctx_d;
            pv_q      <= pv_d;
            pe_q      <= pe_d;
            pd_q      <= pd_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_ibex_rf_backing_store.sv
// tb/tb_ibex_rf_backing_store.sv - directed vector bench for ibex_rf_backing_store (RespLatency = 3)
module tb_ibex_rf_backing_store;

    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef IBEX_RFSTORE_CTX_VALID_EN
    localparam logic VEN = 1'b1;
`else
    localparam logic VEN = 1'b0;
`endif

    logic        clk, rst;
    logic        req, gnt, we, rvalid, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        clear_req, busy, done;
    logic [1:0]  clear_ctx;

    ibex_rf_backing_store #(
        .BaseAddr   (BASE),
        .NumCtx     (4),
        .RespLatency(LAT)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (req),
        .data_gnt_o   (gnt),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_rvalid_o(rvalid),
        .data_rdata_o (rdata),
        .data_err_o   (err),
        .clear_req_i  (clear_req),
        .clear_ctx_i  (clear_ctx),
        .clear_busy_o (busy),
        .clear_done_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rd;
    } resp_t;
    resp_t q[$];

    logic        exp_err_cur;
    logic [31:0] exp_rd_cur;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            check("rvalid_in_reset", rvalid, 0);
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                check("rvalid", rvalid, 1);
                check("resp_err", err, q[0].err);
                check("resp_rdata", rdata, q[0].rd);
                void'(q.pop_front());
            end else begin
                check("rvalid_unexpected", rvalid, 0);
            end
            if (gnt) q.push_back('{cyc + LAT, exp_err_cur, exp_rd_cur});
        end
    end

    task automatic set_bus(input logic w, input logic [3:0] b, input logic [31:0] a,
                           input logic [31:0] d, input logic e, input logic [31:0] r);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        exp_err_cur = e; exp_rd_cur = r;
    endtask

    task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input logic e, input logic [31:0] r);
        set_bus(w, b, a, d, e, r);
        @(negedge clk);
        check("gnt", gnt, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    endtask

    function automatic logic [31:0] wa(input int ctx, input int word);
        return BASE + 32'(ctx * 128 + word * 4);
    endfunction

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
    } vec_t;
    vec_t vt[15];

    int low_n, busy_n, done_n;
    logic got;

    initial begin
        vt[0]  = '{1'b1, 4'hF, 32'h0001_0094, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 4'hF, 32'h0001_0094, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 4'hF, 32'h0001_0180, 32'h1122_3344, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 4'h2, 32'h0001_0180, 32'h0000_AB00, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 4'hF, 32'h0001_0180, 32'h0,         1'b0, 32'h1122_AB44};
        vt[5]  = '{1'b1, 4'h0, 32'h0001_0180, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 4'hF, 32'h0001_0180, 32'h0,         1'b0, 32'h1122_AB44};
        vt[7]  = '{1'b1, 4'hF, 32'h0001_0200, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vt[8]  = '{1'b0, 4'hF, 32'h0001_0200, 32'h0,         1'b1, 32'h0};
        vt[9]  = '{1'b1, 4'hF, 32'h0000_0200, 32'h5555_5555, 1'b1, 32'h0};
        vt[10] = '{1'b1, 4'hF, 32'h0001_0000, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vt[11] = '{1'b1, 4'h9, 32'h0001_007C, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vt[12] = '{1'b0, 4'hF, 32'h0001_0000, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vt[13] = '{1'b0, 4'hF, 32'h0001_007C, 32'h0,         1'b0, 32'hFF00_00FF};
        vt[14] = '{1'b0, 4'hF, 32'h0001_0002, 32'h0,         1'b0, 32'hA5A5_A5A5};

        // Reset state, with a request pending that must not be granted.
        rst = 1'b1; clear_req = 1'b0; clear_ctx = '0;
        exp_err_cur = 1'b0; exp_rd_cur = '0;
        set_bus(1'b0, 4'hF, wa(1, 5), 32'h0, 1'b0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt", gnt, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rdata", rdata, 0);
            check("rst_err", err, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1'b0, 4'hF, wa(1, 5), 32'h0, VEN, 32'h0);
        idle();

        // Table vectors, issued back to back.
        for (int i = 0; i < 15; i++) begin
            issue(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, vt[i].err, vt[i].rd);
        end
        idle();
        repeat (LAT + 1) @(posedge clk);
        #1;

        // 32 writes then 32 reads of ctx2 with req held high.
        for (int i = 0; i < 32; i++) issue(1'b1, 4'hF, wa(2, i), {16'hC2C2, 16'(i)}, 1'b0, 32'h0);
        for (int i = 0; i < 32; i++) issue(1'b0, 4'hF, wa(2, i), 32'h0, 1'b0, {16'hC2C2, 16'(i)});
        idle();
        repeat (LAT + 1) @(posedge clk);
        #1;

        // Clear ctx0 while a read is requested in the same cycle.
        set_bus(1'b0, 4'hF, wa(1, 5), 32'h0, 1'b0, 32'hDEAD_BEEF);
        clear_req = 1'b1; clear_ctx = 2'd0;
        low_n = 0; busy_n = 0; done_n = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt) got = 1'b1;
            else low_n++;
            if (busy) busy_n++;
            if (done) done_n++;
            @(posedge clk); #1;
            clear_req = 1'b0;
        end
        idle();
        check("clear_gnt_eventually", got, 1);
        check("clear_gnt_low_cycles", low_n, 34);
        check("clear_busy_cycles", busy_n, 32);
        check("clear_done_pulses", done_n, 1);
        issue(1'b0, 4'hF, wa(0, 0), 32'h0, VEN, 32'h0);
        issue(1'b0, 4'hF, wa(0, 31), 32'h0, VEN, 32'h0);
        issue(1'b0, 4'hF, wa(2, 7), 32'h0, 1'b0, 32'hC2C2_0007);
        issue(1'b1, 4'hF, wa(0, 4), 32'h0BAD_F00D, 1'b0, 32'h0);
        issue(1'b0, 4'hF, wa(0, 4), 32'h0, 1'b0, 32'h0BAD_F00D);
        idle();
        repeat (LAT + 1) @(posedge clk);
        #1;

        // Reset with two responses in flight.
        issue(1'b0, 4'hF, wa(2, 0), 32'h0, 1'b0, 32'hC2C2_0000);
        issue(1'b0, 4'hF, wa(2, 1), 32'h0, 1'b0, 32'hC2C2_0001);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            check("no_rvalid_after_rst", rvalid, 0);
        end
        @(posedge clk); #1;

        // Reset at clear word 10.
        issue(1'b1, 4'hF, wa(2, 3), 32'h1234_5678, 1'b0, 32'h0);
        idle();
        repeat (LAT) @(posedge clk);
        #1;
        clear_req = 1'b1; clear_ctx = 2'd2;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check("busy_at_word10", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("busy_in_rst", busy, 0);
        check("done_in_rst", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("busy_after_rst", busy, 0);
        @(posedge clk); #1;
        issue(1'b0, 4'hF, wa(2, 3), 32'h0, VEN, 32'h0);
        issue(1'b0, 4'hF, wa(2, 7), 32'h0, VEN, 32'h0);
        issue(1'b0, 4'hF, wa(1, 5), 32'h0, VEN, 32'h0);
        issue(1'b0, 4'hF, wa(0, 4), 32'h0, VEN, 32'h0);
        issue(1'b0, 4'hF, wa(3, 0), 32'h0, VEN, 32'h0);
        idle();
        repeat (LAT + 2) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
